// File: rtl/pa_fdsu_seq_ctrl.sv
// Sequencing controller for the FDSU divide/sqrt pipeline: EX1 -> ITER -> RND -> PACK -> WB.
// Optional macro PA_FDSU_EARLY_TERM_EN ends ITER early when the partial remainder is zero.
module pa_fdsu_seq_ctrl #(
   parameter int unsigned DIV_ITER  = 13,
   parameter int unsigned SQRT_ITER = 14,
   parameter int unsigned CNT_W     = 4
) (
   input  logic             forever_cpuclk,
   input  logic             cpurst,
   input  logic             idu_fdsu_issue_vld,
   input  logic             idu_fdsu_op_sqrt,
   input  logic [4:0]       idu_fdsu_wb_freg,
   output logic             fdsu_idu_issue_rdy,
   input  logic             ctrl_fdsu_flush,
   input  logic             fdsu_ex1_special,
   input  logic             fdsu_ex2_rem_zero,
   input  logic             frbus_fdsu_wb_grant,
   output logic             fdsu_ex1_sel,
   output logic             fdsu_ex2_iter_en,
   output logic             fdsu_ex2_iter_first,
   output logic [CNT_W-1:0] fdsu_ex2_iter_cnt,
   output logic             fdsu_ex3_rnd_en,
   output logic             fdsu_ex4_pack_en,
   output logic             fdsu_frbus_wb_vld,
   output logic [4:0]       fdsu_yy_wb_freg,
   output logic             fdsu_yy_op_sqrt,
   output logic             fdsu_yy_special,
   output logic             fdsu_yy_busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EX1,
      S_ITER,
      S_RND,
      S_PACK,
      S_WB
   } state_t;

   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_ITER - 1);
   localparam logic [CNT_W-1:0] SQRT_LOAD = CNT_W'(SQRT_ITER - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             first_q, first_d;
   logic [4:0]       wb_freg_q, wb_freg_d;
   logic             op_sqrt_q, op_sqrt_d;
   logic             special_q, special_d;
   logic             accept;
   logic             early_term;

`ifdef PA_FDSU_EARLY_TERM_EN
   // The first ITER cycle only loads the remainder, so rem_zero is not yet meaningful.
   assign early_term = fdsu_ex2_rem_zero && !first_q;
`else
   logic unused_rem_zero;
   assign unused_rem_zero = fdsu_ex2_rem_zero;
   assign early_term      = 1'b0;
`endif

   assign accept = idu_fdsu_issue_vld && fdsu_idu_issue_rdy;

   always_comb begin
      state_d             = state_q;
      cnt_d               = cnt_q;
      first_d             = first_q;
      wb_freg_d           = wb_freg_q;
      op_sqrt_d           = op_sqrt_q;
      special_d           = special_q;
      fdsu_ex1_sel        = 1'b0;
      fdsu_ex2_iter_en    = 1'b0;
      fdsu_ex2_iter_first = 1'b0;
      fdsu_ex3_rnd_en     = 1'b0;
      fdsu_ex4_pack_en    = 1'b0;
      fdsu_frbus_wb_vld   = 1'b0;
      fdsu_idu_issue_rdy  = (state_q == S_IDLE) && !ctrl_fdsu_flush && !cpurst;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_EX1;
               wb_freg_d = idu_fdsu_wb_freg;
               op_sqrt_d = idu_fdsu_op_sqrt;
            end
         end
         S_EX1: begin
            fdsu_ex1_sel = 1'b1;
            special_d    = fdsu_ex1_special;
            if (fdsu_ex1_special) begin
               state_d = S_PACK;
            end else begin
               state_d = S_ITER;
               cnt_d   = op_sqrt_q ? SQRT_LOAD : DIV_LOAD;
               first_d = 1'b1;
            end
         end
         S_ITER: begin
            fdsu_ex2_iter_en    = 1'b1;
            fdsu_ex2_iter_first = first_q;
            first_d             = 1'b0;
            if (early_term) begin
               state_d = S_RND;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = S_RND;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RND: begin
            fdsu_ex3_rnd_en = 1'b1;
            state_d         = S_PACK;
         end
         S_PACK: begin
            fdsu_ex4_pack_en = 1'b1;
            state_d          = S_WB;
         end
         S_WB: begin
            fdsu_frbus_wb_vld = 1'b1;
            if (frbus_fdsu_wb_grant) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Flush aborts from any busy state; a grant in the same WB cycle lands in IDLE too.
      if (ctrl_fdsu_flush && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         first_q   <= 1'b0;
         wb_freg_q <= '0;
         op_sqrt_q <= 1'b0;
         special_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         first_q   <= first_d;
         wb_freg_q <= wb_freg_d;
         op_sqrt_q <= op_sqrt_d;
         special_q <= special_d;
      end
   end

   assign fdsu_ex2_iter_cnt = cnt_q;
   assign fdsu_yy_wb_freg   = wb_freg_q;
   assign fdsu_yy_op_sqrt   = op_sqrt_q;
   assign fdsu_yy_special   = special_q;
   assign fdsu_yy_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_pa_fdsu_seq_ctrl.sv
// Directed bench for pa_fdsu_seq_ctrl; cycle 0 of each scenario is the issue-accept cycle.
// Expectations follow PA_FDSU_EARLY_TERM_EN when the bench is built with it.
module tb_pa_fdsu_seq_ctrl;

   logic       clk;
   logic       cpurst;
   logic       issue_vld;
   logic       op_sqrt;
   logic [4:0] wb_freg_in;
   logic       issue_rdy;
   logic       flush;
   logic       ex1_special;
   logic       rem_zero;
   logic       grant;
   logic       ex1_sel;
   logic       iter_en;
   logic       iter_first;
   logic [3:0] iter_cnt;
   logic       rnd_en;
   logic       pack_en;
   logic       wb_vld;
   logic [4:0] yy_freg;
   logic       yy_op_sqrt;
   logic       yy_special;
   logic       busy;

   int vectors     = 0;
   int miscompares = 0;

   pa_fdsu_seq_ctrl #(
      .DIV_ITER  (13),
      .SQRT_ITER (14),
      .CNT_W     (4)
   ) dut (
      .forever_cpuclk      (clk),
      .cpurst              (cpurst),
      .idu_fdsu_issue_vld  (issue_vld),
      .idu_fdsu_op_sqrt    (op_sqrt),
      .idu_fdsu_wb_freg    (wb_freg_in),
      .fdsu_idu_issue_rdy  (issue_rdy),
      .ctrl_fdsu_flush     (flush),
      .fdsu_ex1_special    (ex1_special),
      .fdsu_ex2_rem_zero   (rem_zero),
      .frbus_fdsu_wb_grant (grant),
      .fdsu_ex1_sel        (ex1_sel),
      .fdsu_ex2_iter_en    (iter_en),
      .fdsu_ex2_iter_first (iter_first),
      .fdsu_ex2_iter_cnt   (iter_cnt),
      .fdsu_ex3_rnd_en     (rnd_en),
      .fdsu_ex4_pack_en    (pack_en),
      .fdsu_frbus_wb_vld   (wb_vld),
      .fdsu_yy_wb_freg     (yy_freg),
      .fdsu_yy_op_sqrt     (yy_op_sqrt),
      .fdsu_yy_special     (yy_special),
      .fdsu_yy_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      cpurst      = 1'b1;
      issue_vld   = 1'b0;
      op_sqrt     = 1'b0;
      wb_freg_in  = '0;
      flush       = 1'b0;
      ex1_special = 1'b0;
      rem_zero    = 1'b0;
      grant       = 1'b0;

      // ---------------- reset state
      cyc();
      cyc();
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_wb_vld", wb_vld, 0);
      cpurst = 1'b0;
      #1;
      chk("rst_rdy", issue_rdy, 1);
      chk("rst_cnt", iter_cnt, 0);
      chk("rst_freg", yy_freg, 0);
      chk("rst_enables", {ex1_sel, iter_en, iter_first, rnd_en, pack_en, yy_op_sqrt, yy_special}, 0);

      // ---------------- divide, freg 7, grant on first WB cycle
      cyc(); issue_vld = 1'b1; op_sqrt = 1'b0; wb_freg_in = 5'd7; #1;
      chk("div_c0_rdy", issue_rdy, 1);
      cyc(); issue_vld = 1'b0; #1;
      chk("div_c1_ex1", ex1_sel, 1);
      chk("div_c1_rdy", issue_rdy, 0);
      chk("div_c1_busy", busy, 1);
      for (int c = 2; c <= 14; c++) begin
         cyc(); #1;
         chk("div_iter_en", iter_en, 1);
         chk("div_iter_cnt", iter_cnt, 14 - c);
         chk("div_iter_first", iter_first, (c == 2) ? 1 : 0);
         chk("div_iter_rnd", rnd_en, 0);
      end
      cyc(); #1;
      chk("div_c15_rnd", rnd_en, 1);
      chk("div_c15_iter", iter_en, 0);
      cyc(); #1;
      chk("div_c16_pack", pack_en, 1);
      chk("div_c16_wb", wb_vld, 0);
      cyc(); grant = 1'b1; #1;
      chk("div_c17_wb", wb_vld, 1);
      chk("div_c17_freg", yy_freg, 7);
      chk("div_c17_op", yy_op_sqrt, 0);
      cyc(); grant = 1'b0; #1;
      chk("div_c18_busy", busy, 0);
      chk("div_c18_rdy", issue_rdy, 1);
      chk("div_c18_wb", wb_vld, 0);

      // ---------------- sqrt, freg 9, grant withheld until cycle 22
      issue_vld = 1'b1; op_sqrt = 1'b1; wb_freg_in = 5'd9; #1;
      chk("sq_c0_rdy", issue_rdy, 1);
      cyc(); issue_vld = 1'b0; op_sqrt = 1'b0; #1;
      chk("sq_c1_ex1", ex1_sel, 1);
      chk("sq_c1_op", yy_op_sqrt, 1);
      for (int c = 2; c <= 15; c++) begin
         cyc(); #1;
         chk("sq_iter_en", iter_en, 1);
         chk("sq_iter_cnt", iter_cnt, 15 - c);
      end
      cyc(); #1;
      chk("sq_c16_rnd", rnd_en, 1);
      cyc(); #1;
      chk("sq_c17_pack", pack_en, 1);
      chk("sq_c17_wb", wb_vld, 0);
      for (int c = 18; c <= 22; c++) begin
         cyc(); grant = (c == 22); #1;
         chk("sq_wb_hold", wb_vld, 1);
         chk("sq_wb_freg", yy_freg, 9);
      end
      cyc(); grant = 1'b0; #1;
      chk("sq_c23_busy", busy, 0);
      chk("sq_c23_wb", wb_vld, 0);

      // ---------------- special result from EX1, freg 3
      issue_vld = 1'b1; wb_freg_in = 5'd3; #1;
      cyc(); issue_vld = 1'b0; ex1_special = 1'b1; #1;
      chk("sp_c1_ex1", ex1_sel, 1);
      cyc(); ex1_special = 1'b0; #1;
      chk("sp_c2_pack", pack_en, 1);
      chk("sp_c2_iter", iter_en, 0);
      chk("sp_c2_rnd", rnd_en, 0);
      chk("sp_c2_special", yy_special, 1);
      cyc(); grant = 1'b1; #1;
      chk("sp_c3_wb", wb_vld, 1);
      chk("sp_c3_freg", yy_freg, 3);
      cyc(); grant = 1'b0; #1;
      chk("sp_c4_busy", busy, 0);

      // ---------------- flush during ITER at cycle 6, re-issue at 7
      issue_vld = 1'b1; wb_freg_in = 5'd4; #1;
      cyc(); issue_vld = 1'b0; #1;
      chk("fl_c1_special", yy_special, 1);
      cyc(); #1;
      chk("fl_c2_special", yy_special, 0);
      cyc(); cyc(); cyc();
      cyc(); flush = 1'b1; #1;
      chk("fl_c6_iter", iter_en, 1);
      chk("fl_c6_cnt", iter_cnt, 8);
      chk("fl_c6_rdy", issue_rdy, 0);
      cyc(); flush = 1'b0; #1;
      chk("fl_c7_iter", iter_en, 0);
      chk("fl_c7_busy", busy, 0);
      chk("fl_c7_rdy", issue_rdy, 1);
      issue_vld = 1'b1; wb_freg_in = 5'd12; #1;
      cyc(); issue_vld = 1'b0; #1;
      chk("fl_c8_ex1", ex1_sel, 1);
      for (int c = 9; c <= 23; c++) begin
         cyc(); #1;
         chk("fl_no_wb", wb_vld, 0);
      end
      // WB at 24 with flush and grant together
      cyc(); flush = 1'b1; grant = 1'b1; #1;
      chk("fg_c24_wb", wb_vld, 1);
      chk("fg_c24_freg", yy_freg, 12);
      cyc(); flush = 1'b0; grant = 1'b0; #1;
      chk("fg_c25_busy", busy, 0);
      chk("fg_c25_wb", wb_vld, 0);
      chk("fg_c25_rdy", issue_rdy, 1);
      cyc(); #1;
      chk("fg_c26_wb", wb_vld, 0);

      // ---------------- issue during flush in IDLE is refused
      flush = 1'b1; issue_vld = 1'b1; wb_freg_in = 5'd20; #1;
      chk("fi_rdy", issue_rdy, 0);
      cyc(); flush = 1'b0; issue_vld = 1'b0; #1;
      chk("fi_busy", busy, 0);
      chk("fi_ex1", ex1_sel, 0);
      chk("fi_freg", yy_freg, 12);

      // ---------------- early termination stimulus, rem_zero at cycles 2 and 5
      issue_vld = 1'b1; wb_freg_in = 5'd2; #1;
      cyc(); issue_vld = 1'b0; #1;
      cyc(); rem_zero = 1'b1; #1;
      chk("et_c2_first", iter_first, 1);
      cyc(); rem_zero = 1'b0; #1;
      chk("et_c3_iter", iter_en, 1);
      chk("et_c3_cnt", iter_cnt, 11);
      cyc(); #1;
      cyc(); rem_zero = 1'b1; #1;
      chk("et_c5_cnt", iter_cnt, 9);
      cyc(); rem_zero = 1'b0; #1;
`ifdef PA_FDSU_EARLY_TERM_EN
      chk("et_c6_rnd", rnd_en, 1);
      chk("et_c6_cnt", iter_cnt, 0);
      cyc(); #1;
      chk("et_c7_pack", pack_en, 1);
      cyc(); grant = 1'b1; #1;
      chk("et_c8_wb", wb_vld, 1);
`else
      chk("et_c6_iter", iter_en, 1);
      chk("et_c6_cnt", iter_cnt, 8);
      for (int c = 7; c <= 16; c++) begin
         cyc(); #1;
         chk("et_no_wb", wb_vld, 0);
      end
      cyc(); grant = 1'b1; #1;
      chk("et_c17_wb", wb_vld, 1);
`endif
      cyc(); grant = 1'b0; #1;
      chk("et_done_busy", busy, 0);

      // ---------------- reset mid-operation
      issue_vld = 1'b1; wb_freg_in = 5'd17; #1;
      cyc(); issue_vld = 1'b0; #1;
      cyc(); cyc(); cpurst = 1'b1; #1;
      cyc(); #1;
      chk("rm_busy", busy, 0);
      chk("rm_iter", iter_en, 0);
      chk("rm_freg", yy_freg, 0);
      cpurst = 1'b0; #1;
      chk("rm_rdy", issue_rdy, 1);
      for (int c = 0; c < 16; c++) begin
         cyc(); #1;
         chk("rm_idle_wb", wb_vld, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pa_fdsu_seq_ctrl.md
Name: pa_fdsu_seq_ctrl

Overview:
- Sequencing controller for the single-precision divide/sqrt unit (FDSU).
- Accepts one operation at a time from the issue stage and steps the datapath through EX1 (operand prep/special detect), EX2 (iterative radix-4 SRT), EX3 (round) and EX4 (pack).
- Holds the packed result on the FP result bus until the bus grants it.
- Owns the busy indication, the iteration counter, flush handling and the latched writeback register index consumed by the pack stage.

Parameters:
- DIV_ITER, 13, EX2 iteration count for divide (2 quotient bits per iteration).
- SQRT_ITER, 14, EX2 iteration count for square root.
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W > max(DIV_ITER, SQRT_ITER).

Ports:
- forever_cpuclk  in  1  sole clock, all state on rising edge.
- cpurst  in  1  reset, synchronous, active-high.
- idu_fdsu_issue_vld  in  1  issue request.
- idu_fdsu_op_sqrt  in  1  1=sqrt, 0=div; sampled on accept.
- idu_fdsu_wb_freg  in  5  destination FP register; sampled on accept.
- fdsu_idu_issue_rdy  out  1  may accept issue this cycle.
- ctrl_fdsu_flush  in  1  pipeline flush; abort in-flight op.
- fdsu_ex1_special  in  1  EX1 found special result (NaN/inf/zero/dz); valid in EX1 only.
- fdsu_ex2_rem_zero  in  1  partial remainder is zero; used only with optional feature.
- frbus_fdsu_wb_grant  in  1  result bus accepts writeback.
- fdsu_ex1_sel  out  1  EX1 stage enable.
- fdsu_ex2_iter_en  out  1  EX2 iteration enable.
- fdsu_ex2_iter_first  out  1  first EX2 cycle (load remainder).
- fdsu_ex2_iter_cnt  out  CNT_W  remaining iterations after the current one.
- fdsu_ex3_rnd_en  out  1  EX3 round enable.
- fdsu_ex4_pack_en  out  1  EX4 pack enable.
- fdsu_frbus_wb_vld  out  1  result valid on bus.
- fdsu_yy_wb_freg  out  5  latched destination register.
- fdsu_yy_op_sqrt  out  1  latched op type.
- fdsu_yy_special  out  1  latched EX1 special flag.
- fdsu_yy_busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, EX1, ITER, RND, PACK, WB; one-hot or encoded at implementer's choice.
- Reset: state=IDLE. Counter, wb_freg, op_sqrt and special all 0. Every output 0 except fdsu_idu_issue_rdy, which is 1 once cpurst deasserts.
- fdsu_idu_issue_rdy = (state==IDLE) && !ctrl_fdsu_flush. Accept = issue_vld && issue_rdy. On accept, latch freg/op_sqrt; next state EX1.
- EX1 (1 cycle), fdsu_ex1_sel=1:
  - Latch fdsu_ex1_special.
  - special=1 → PACK, skipping ITER and RND.
  - special=0 → ITER; counter loaded with (op_sqrt ? SQRT_ITER : DIV_ITER) - 1.
- ITER, iter_en=1: iter_first=1 on first ITER cycle only. iter_cnt shows the counter. Decrement each cycle; when counter==0 → RND.
- RND (1 cycle), rnd_en=1 → PACK.
- PACK (1 cycle), pack_en=1 → WB.
- WB: wb_vld=1 held with freg stable until grant. Grant in WB → IDLE next cycle. Grant outside WB is ignored.
- Latency, issue accept at cycle 0:
  - div: EX1@1, ITER@2..14, RND@15, PACK@16, wb_vld from 17.
  - sqrt: wb_vld from 18.
  - special: EX1@1, PACK@2, wb_vld from 3.
- No overlap: next issue is accepted only in IDLE, at the earliest the cycle after grant.
- Flush in any non-IDLE state → IDLE next cycle. All stage enables and wb_vld drop at that edge; latched fields are retained but don't-care.
- Flush coinciding with grant in WB: grant wins, writeback counted complete, IDLE next cycle (same as grant alone).
- Flush in IDLE with issue_vld: not accepted.
- cpurst mid-operation: IDLE next edge regardless of other inputs; no wb_vld.
- Counter never wraps: it decrements only in ITER and ITER exits at 0.

Optional Feature:
- Macro PA_FDSU_EARLY_TERM_EN.
- Defined: in ITER, when fdsu_ex2_rem_zero=1 and iter_first=0, go to RND next cycle regardless of counter. The counter is cleared to 0 on that exit.
- Undefined: fdsu_ex2_rem_zero is ignored and all iterations always run.

Test Plan:
- Reset then div issue freg=5'd7 → issue_rdy=0 from cycle 1, iter_en high cycles 2–14 with iter_cnt 12→0, wb_vld at 17 with fdsu_yy_wb_freg=7; grant at 17 → busy=0 and issue_rdy=1 at 18.
- sqrt issue, grant withheld until cycle 22 → wb_vld stays 1 for cycles 18–22; IDLE at 23.
- div issue with fdsu_ex1_special=1 in EX1 → iter_en and rnd_en never assert, pack_en@2, wb_vld@3, fdsu_yy_special=1.
- flush at cycle 6 during ITER → iter_en=0 and busy=0 at 7, no wb_vld; new issue accepted at 7.
- WB with flush and grant in the same cycle → single writeback observed, IDLE next cycle. Issue_vld during a flush in IDLE → not accepted.
- With PA_FDSU_EARLY_TERM_EN: rem_zero=1 at cycle 5 → rnd_en@6, wb_vld@8. Without the macro: same stimulus gives wb_vld@17.
